systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the signed activation width in bits.
REQ-002 Parameter HIDDEN_SIZE, default 4, SHALL set H, the reduction depth (K) and the number of output columns.
REQ-003 Parameter CONTEXT_LENGTH, default 4, SHALL set R, the number of activation rows (output rows).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 X_in  input  R x H x WIDTH signed  SHALL be activation matrix X[r][k], held stable for a whole run.
REQ-007 W_in  input  H x H x 2  SHALL be ternary weight matrix W[k][c], held stable for a whole run.
REQ-008 Y_out  output  R x H x 2*WIDTH signed  SHALL be result matrix Y[r][c].
REQ-009 done  output  1  SHALL flag that Y_out holds the final result.

Function
REQ-010 Weight decode: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; 2'b10 SHALL decode to 0.
REQ-011 Result: Y[r][c] SHALL equal sum over k of X[r][k]*W[k][c], computed without multipliers (add, subtract or skip per weight).
REQ-012 Arithmetic: X SHALL be sign-extended to 2*WIDTH before accumulation; overflow SHALL wrap modulo 2^(2*WIDTH).
REQ-013 Array: R x H output-stationary PEs; PE(r,c) owns accumulator Y[r][c].
REQ-014 Data movement: activations SHALL move one PE right per cycle; weights SHALL move one PE down per cycle.
REQ-015 Skew: an internal cycle counter t SHALL start at 0 on the first rising edge after reset release.
REQ-016 Left-edge injection: at counter value t, PE row r SHALL receive X[r][t-r], or 0 when t-r is outside 0..H-1.
REQ-017 Top-edge injection: at counter value t, PE column c SHALL receive W[t-c][c], or 0 when t-c is outside 0..H-1.
REQ-018 Operand pairing: each PE SHALL pair operands with matching k.
REQ-019 Latency: done SHALL rise after exactly LAT = R + 2H - 1 rising edges following reset release.
REQ-020 Completion hold: once done is 1, the counter SHALL saturate, Y_out and done SHALL hold, and injected operands SHALL be 0.
REQ-021 Before done, Y_out SHALL show partial sums; only values with done=1 are defined results.
REQ-022 Input changes after the start of a run SHALL have undefined effect; a new run requires a reset pulse.

Reset
REQ-023 While reset=1: all accumulators, the Y_out bits, all skew/forwarding registers and the counter SHALL be 0, and done SHALL be 0.
REQ-024 Reset asserted mid-run SHALL abort the run immediately (asynchronously); a new run SHALL start on the first edge after release.

Structure
REQ-025 Shared package systolic_pkg SHALL hold the ternary encoding constants (W_POS=2'b01, W_NEG=2'b11, W_ZERO=2'b00) and a decode function.
REQ-026 One sub-module systolic_pe SHALL contain:
  - the forwarding registers for activation and weight;
  - the 2*WIDTH accumulator;
  - the add/sub/skip select.
REQ-027 systolic_array SHALL contain the counter, the edge skew logic, the generate grid of PEs and the done flag.

Verification
REQ-028 Worked example, R=H=4, WIDTH=16:
  - X rows: [5,-2,7,9], [3,10,-4,5], [0,1,4,-7], [3,5,-9,2].
  - W rows: [+1,0,-1,+1], [0,+1,-1,0], [-1,-1,+1,+1], [+1,0,0,-1].
  - At done, Y SHALL equal rows [7,-9,4,3], [12,14,-17,-6], [-11,-3,3,11], [14,14,-17,-8].
  - done SHALL rise after exactly 11 edges.
REQ-029 All weights 2'b00 (also all 2'b10), any X -> Y all 0 at done.
REQ-030 W = identity, X as in REQ-028 -> Y equals X; a second run after a reset pulse with X negated -> Y equals -X.
REQ-031 X all 16'sh8000, W all +1 -> every Y = -131072 (sign extension holds); W all -1 -> every Y = +131072.
REQ-032 Reset asserted at edge 5 of the REQ-028 run -> Y_out and done go 0 immediately; after release, full correct result after 11 edges.
REQ-033 Non-square case R=2, H=3 -> correct Y and done after 7 edges; Y_out and done remain stable for 20 further cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the ternary-weight systolic array: weight encodings
// and the decode of a 2-bit weight into the PE's accumulate operation.
package systolic_pkg;

    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_ZERO = 2'b00;

    typedef enum logic [1:0] {
        OP_SKIP = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } pe_op_t;

    // The unused code 2'b10 falls into the default and behaves like a zero weight.
    function automatic pe_op_t decode_weight(input logic [1:0] w);
        case (w)
            W_POS:   return OP_ADD;
            W_NEG:   return OP_SUB;
            default: return OP_SKIP;
        endcase
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: registers the incoming activation and
// weight, forwards them right/down, and adds/subtracts/skips into its accumulator.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [1:0]           w_in,
    output logic [WIDTH-1:0]     a_out,
    output logic [1:0]           w_out,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] a_ext;

    // Operands are consumed from the forwarding registers, so a pair entering
    // this PE on one edge is accumulated on the next.
    assign a_ext = {{WIDTH{a_out[WIDTH-1]}}, a_out};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            w_out <= W_ZERO;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            w_out <= w_in;
            if (en) begin
                case (decode_weight(w_out))
                    OP_ADD:  acc <= acc + a_ext;
                    OP_SUB:  acc <= acc - a_ext;
                    default: acc <= acc;
                endcase
            end
        end
    end

endmodule

// File: rtl/systolic_array.sv
// R x H output-stationary systolic array computing Y = X * W with ternary W.
// Holds the run counter, the edge skew injection, the PE grid and done.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 4,
    parameter int CONTEXT_LENGTH = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [CONTEXT_LENGTH*HIDDEN_SIZE*WIDTH-1:0]     X_in,
    input  logic [HIDDEN_SIZE*HIDDEN_SIZE*2-1:0]            W_in,
    output logic [CONTEXT_LENGTH*HIDDEN_SIZE*2*WIDTH-1:0]   Y_out,
    output logic                                            done
);

    localparam int H   = HIDDEN_SIZE;
    localparam int R   = CONTEXT_LENGTH;
    localparam int LAT = R + 2*H - 1;
    localparam int CW  = $clog2(LAT + 1);
    localparam int KW  = (H > 1) ? $clog2(H) : 1;

    logic [CW-1:0]    t;
    logic [WIDTH-1:0] x_mat  [R][H];
    logic [1:0]       w_mat  [H][H];
    logic [WIDTH-1:0] a_left [R];
    logic [1:0]       w_top  [H];
    logic [WIDTH-1:0] a_q    [R][H];
    logic [1:0]       w_q    [R][H];

    // Counter saturates at LAT once done is set, freezing injection at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t    <= '0;
            done <= 1'b0;
        end else if (!done) begin
            t <= t + CW'(1);
            if (t == CW'(LAT - 1))
                done <= 1'b1;
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_xmat
        for (genvar k = 0; k < H; k++) begin : g_xk
            assign x_mat[r][k] = X_in[(r*H + k)*WIDTH +: WIDTH];
        end
    end

    for (genvar k = 0; k < H; k++) begin : g_wmat
        for (genvar c = 0; c < H; c++) begin : g_wc
            assign w_mat[k][c] = W_in[(k*H + c)*2 +: 2];
        end
    end

    // Row r is delayed by r cycles so X[r][k] meets W[k][c] in PE(r,c).
    for (genvar r = 0; r < R; r++) begin : g_left
        int k;
        always_comb begin
            k         = int'(t) - r;
            a_left[r] = '0;
            if (!done && k >= 0 && k < H)
                a_left[r] = x_mat[r][k[KW-1:0]];
        end
    end

    for (genvar c = 0; c < H; c++) begin : g_top
        int k;
        always_comb begin
            k        = int'(t) - c;
            w_top[c] = W_ZERO;
            if (!done && k >= 0 && k < H)
                w_top[c] = w_mat[k[KW-1:0]][c];
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_row
        for (genvar c = 0; c < H; c++) begin : g_col
            logic [WIDTH-1:0] a_src;
            logic [1:0]       w_src;

            if (c == 0) begin : g_a_edge
                assign a_src = a_left[r];
            end else begin : g_a_fwd
                assign a_src = a_q[r][c-1];
            end

            if (r == 0) begin : g_w_edge
                assign w_src = w_top[c];
            end else begin : g_w_fwd
                assign w_src = w_q[r-1][c];
            end

            systolic_pe #(
                .WIDTH (WIDTH)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (!done),
                .a_in  (a_src),
                .w_in  (w_src),
                .a_out (a_q[r][c]),
                .w_out (w_q[r][c]),
                .acc   (Y_out[(r*H + c)*2*WIDTH +: 2*WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: a 4x4 instance and a 2x3 instance, each
// with a scoreboard queue filled by the driver and drained by a done monitor.
module tb_systolic_array;

    localparam int WIDTH = 16;
    localparam int R     = 4;
    localparam int H     = 4;
    localparam int R2    = 2;
    localparam int H2    = 3;
    localparam int YW    = R*H*2*WIDTH;
    localparam int YW2   = R2*H2*2*WIDTH;
    localparam int LAT4  = 11;
    localparam int LAT2  = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rst2;
    logic [R*H*WIDTH-1:0]    x_in;
    logic [H*H*2-1:0]        w_in;
    logic [YW-1:0]           y_out;
    logic                    done;
    logic [R2*H2*WIDTH-1:0]  x_in2;
    logic [H2*H2*2-1:0]      w_in2;
    logic [YW2-1:0]          y_out2;
    logic                    done2;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    systolic_array #(.WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(R)) dut (
        .clk   (clk),
        .reset (rst),
        .X_in  (x_in),
        .W_in  (w_in),
        .Y_out (y_out),
        .done  (done)
    );

    systolic_array #(.WIDTH(WIDTH), .HIDDEN_SIZE(H2), .CONTEXT_LENGTH(R2)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .X_in  (x_in2),
        .W_in  (w_in2),
        .Y_out (y_out2),
        .done  (done2)
    );

    int cyc4;
    int cyc2;
    always @(posedge clk or posedge rst)
        if (rst) cyc4 <= 0; else cyc4 <= cyc4 + 1;
    always @(posedge clk or posedge rst2)
        if (rst2) cyc2 <= 0; else cyc2 <= cyc2 + 1;

    // ---------------- stimulus tables ----------------
    int ex_x[R][H] = '{'{5, -2, 7, 9}, '{3, 10, -4, 5}, '{0, 1, 4, -7}, '{3, 5, -9, 2}};
    int ex_w[H][H] = '{'{1, 0, -1, 1}, '{0, 1, -1, 0}, '{-1, -1, 1, 1}, '{1, 0, 0, -1}};
    int ex_y[R][H] = '{'{7, -9, 4, 3}, '{12, 14, -17, -6}, '{-11, -3, 3, 11}, '{14, 14, -17, -8}};

    int tx2[R2][H2] = '{'{4, -3, 6}, '{-1, 2, 8}};
    int tw2[H2][H2] = '{'{1, -1, 0}, '{1, 1, -1}, '{0, -1, 1}};
    int ty2[R2][H2] = '{'{1, -13, 9}, '{1, -5, 6}};

    int         xm[R][H];
    int         wm[H][H];
    int         ym[R][H];
    logic [1:0] wraw;
    bit         use_raw;

    // ---------------- scoreboard ----------------
    logic [YW-1:0]  exp_q[$];
    logic [YW2-1:0] exp2_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit seen4 = 1'b0;
    bit seen2 = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        if (v > 0) return 2'b01;
        if (v < 0) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [YW-1:0] pack_y4();
        logic [YW-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < H; c++)
                v[(r*H + c)*2*WIDTH +: 2*WIDTH] = (2*WIDTH)'(ym[r][c]);
        return v;
    endfunction

    // Monitor: drains one expectation each time done first rises after a reset.
    initial begin
        logic [YW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done && !seen4) begin
                seen4 = 1'b1;
                check("lat4", longint'(cyc4), longint'(LAT4));
                if (exp_q.size() == 0) begin
                    check("q4_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int r = 0; r < R; r++)
                        for (int c = 0; c < H; c++)
                            check($sformatf("y4[%0d][%0d]", r, c),
                                  longint'($signed(y_out[(r*H + c)*2*WIDTH +: 2*WIDTH])),
                                  longint'($signed(e[(r*H + c)*2*WIDTH +: 2*WIDTH])));
                end
            end
        end
    end

    initial begin
        logic [YW2-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst2 && done2 && !seen2) begin
                seen2 = 1'b1;
                check("lat2", longint'(cyc2), longint'(LAT2));
                if (exp2_q.size() == 0) begin
                    check("q2_empty", 1, 0);
                end else begin
                    e = exp2_q.pop_front();
                    for (int r = 0; r < R2; r++)
                        for (int c = 0; c < H2; c++)
                            check($sformatf("y2[%0d][%0d]", r, c),
                                  longint'($signed(y_out2[(r*H2 + c)*2*WIDTH +: 2*WIDTH])),
                                  longint'($signed(e[(r*H2 + c)*2*WIDTH +: 2*WIDTH])));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load4();
        for (int r = 0; r < R; r++)
            for (int k = 0; k < H; k++)
                x_in[(r*H + k)*WIDTH +: WIDTH] = WIDTH'(xm[r][k]);
        for (int k = 0; k < H; k++)
            for (int c = 0; c < H; c++)
                w_in[(k*H + c)*2 +: 2] = use_raw ? wraw : enc(wm[k][c]);
    endtask

    // Asserts reset (optionally queueing the expectation) and releases it on the next negedge.
    task automatic start4(input bit push, input string tag);
        @(negedge clk);
        rst   = 1'b1;
        seen4 = 1'b0;
        #1;
        check({tag, "_rst_done"}, longint'(done), 0);
        check({tag, "_rst_y"}, longint'(|y_out), 0);
        if (push) exp_q.push_back(pack_y4());
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done4(input string tag);
        for (int i = 0; i < 40 && !seen4; i++) begin
            @(negedge clk);
            #2;
        end
        if (!seen4) begin
            check({tag, "_done_timeout"}, 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic run4(input string tag, input int hold);
        load4();
        start4(1'b1, tag);
        wait_done4(tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_done"}, longint'(done), 1);
            for (int r = 0; r < R; r++)
                for (int c = 0; c < H; c++)
                    check($sformatf("%s_hold_y[%0d][%0d]", tag, r, c),
                          longint'($signed(y_out[(r*H + c)*2*WIDTH +: 2*WIDTH])),
                          longint'(ym[r][c]));
        end
    endtask

    task automatic set_example();
        use_raw = 1'b0;
        xm = ex_x;
        wm = ex_w;
        ym = ex_y;
    endtask

    task automatic set_identity(input int sgn);
        use_raw = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < H; c++) begin
                xm[r][c] = sgn * ex_x[r][c];
                wm[r][c] = (r == c) ? 1 : 0;
                ym[r][c] = sgn * ex_x[r][c];
            end
    endtask

    task automatic set_uniform(input int xv, input int wv, input int yv);
        use_raw = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < H; c++) begin
                xm[r][c] = xv;
                wm[r][c] = wv;
                ym[r][c] = yv;
            end
    endtask

    task automatic run2();
        logic [YW2-1:0] v;
        v = '0;
        for (int r = 0; r < R2; r++)
            for (int k = 0; k < H2; k++)
                x_in2[(r*H2 + k)*WIDTH +: WIDTH] = WIDTH'(tx2[r][k]);
        for (int k = 0; k < H2; k++)
            for (int c = 0; c < H2; c++)
                w_in2[(k*H2 + c)*2 +: 2] = enc(tw2[k][c]);
        for (int r = 0; r < R2; r++)
            for (int c = 0; c < H2; c++)
                v[(r*H2 + c)*2*WIDTH +: 2*WIDTH] = (2*WIDTH)'(ty2[r][c]);
        @(negedge clk);
        rst2  = 1'b1;
        seen2 = 1'b0;
        #1;
        check("nsq_rst_done", longint'(done2), 0);
        check("nsq_rst_y", longint'(|y_out2), 0);
        exp2_q.push_back(v);
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 40 && !seen2; i++) begin
            @(negedge clk);
            #2;
        end
        if (!seen2) begin
            check("nsq_done_timeout", 0, 1);
            exp2_q.delete();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nsq_hold_done", longint'(done2), 1);
            for (int r = 0; r < R2; r++)
                for (int c = 0; c < H2; c++)
                    check($sformatf("nsq_hold_y[%0d][%0d]", r, c),
                          longint'($signed(y_out2[(r*H2 + c)*2*WIDTH +: 2*WIDTH])),
                          longint'(ty2[r][c]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst     = 1'b1;
        rst2    = 1'b1;
        x_in    = '0;
        w_in    = '0;
        x_in2   = '0;
        w_in2   = '0;
        wraw    = 2'b00;
        use_raw = 1'b0;
        repeat (2) @(negedge clk);

        set_example();
        run4("example", 5);

        set_uniform(1234, 0, 0);
        run4("w_zero", 0);

        set_uniform(-777, 0, 0);
        use_raw = 1'b1;
        wraw    = 2'b10;
        run4("w_code10", 0);

        set_identity(1);
        run4("ident_pos", 0);

        set_identity(-1);
        run4("ident_neg", 0);

        set_uniform(-32768, 1, -131072);
        run4("min_pos", 0);

        set_uniform(-32768, -1, 131072);
        run4("min_neg", 0);

        // Abort a run after 5 edges, then let the restarted run complete.
        set_example();
        load4();
        start4(1'b0, "abort_pre");
        repeat (5) @(posedge clk);
        #1;
        check("abort_partial_nonzero", longint'(|y_out), 1);
        rst   = 1'b1;
        seen4 = 1'b0;
        #1;
        check("abort_done", longint'(done), 0);
        check("abort_y", longint'(|y_out), 0);
        exp_q.push_back(pack_y4());
        @(negedge clk);
        rst = 1'b0;
        wait_done4("abort_rerun");

        run2();

        repeat (2) @(negedge clk);
        check("q4_leftover", longint'(exp_q.size()), 0);
        check("q2_leftover", longint'(exp2_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
